// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO word packer: FSM state encodings,
// default word width and a constant-friendly ceil(log2) helper.
// Optional feature macro used by the packer: PACKER_TIMEOUT_EN.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int DEFAULT_BITS = 12;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// Bus bundle for the FIFO word packer: FIFO-side pop interface, flush
// request, the packed valid/ready output stream and the busy flag.
// master = packer side, slave = environment (FIFO + consumer) side.
interface fifo_word_packer_if
    import fifo_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS,
    parameter int PACK = 2
);
    logic                 fifo_ready;
    logic [BITS-1:0]      fifo_data;
    logic                 fifo_read;
    logic                 flush;
    logic [BITS*PACK-1:0] m_data;
    logic [PACK-1:0]      m_keep;
    logic                 m_valid;
    logic                 m_ready;
    logic                 busy;

    modport master (
        input  fifo_ready, fifo_data, flush, m_ready,
        output fifo_read, m_data, m_keep, m_valid, busy
    );

    modport slave (
        output fifo_ready, fifo_data, flush, m_ready,
        input  fifo_read, m_data, m_keep, m_valid, busy
    );
endinterface

// File: rtl/packer_idle_timer.sv
// Saturating idle counter for the packer's auto-flush. expire pulses on the
// enabled cycle whose increment would bring the count to TIMEOUT, so the
// partial beat is closed at that same edge.
module packer_idle_timer #(
    parameter int TIMEOUT   = 8,
    parameter int TIMEOUT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam logic [TIMEOUT_W-1:0] LAST_IDLE = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX   = '1;

    logic [TIMEOUT_W-1:0] count_reg;

    // Count idle cycles, clearing with priority and holding at full scale
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + TIMEOUT_W'(1);
        end
    end

    assign expire = en & ~clr & (count_reg == LAST_IDLE);
endmodule

// File: rtl/fifo_word_packer.sv
// Drains a show-ahead FIFO and packs PACK consecutive BITS-wide words into
// one valid/ready beat, lane 0 holding the first-popped word. Partial beats
// leave on flush; with PACKER_TIMEOUT_EN defined they also leave after
// TIMEOUT idle cycles in FILL.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int BITS      = DEFAULT_BITS,
    parameter int PACK      = 2,
    parameter int TIMEOUT   = 8,
    parameter int TIMEOUT_W = 4
) (
    input  logic clk,
    input  logic rst,
    fifo_word_packer_if.master bus
);
    localparam int CNT_W = clog2(PACK + 1);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [PACK-1:0]      keep_reg, keep_next;
    logic [BITS-1:0]      lane_reg [PACK];
    logic [BITS*PACK-1:0] m_data_comb;

    logic             pop;
    logic             handshake;
    logic             close_req;
    logic             timeout_hit;
    logic [CNT_W-1:0] wr_idx;

    // A held beat only blocks the FIFO until the consumer takes it
    assign pop       = bus.fifo_ready & ~rst & ((state_reg != ST_HOLD) | bus.m_ready);
    assign handshake = (state_reg == ST_HOLD) & bus.m_ready;
    // After a handshake the next word always starts again at lane 0
    assign wr_idx    = handshake ? '0 : cnt_reg;

`ifdef PACKER_TIMEOUT_EN
    logic timer_clr;
    logic timer_en;

    assign timer_clr = (state_reg != ST_FILL) | pop;
    assign timer_en  = (state_reg == ST_FILL) & ~pop;

    packer_idle_timer #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .expire (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT, TIMEOUT_W};
    assign timeout_hit        = 1'b0;
`endif

    // Flush and timeout only matter while a partial beat is being filled
    assign close_req = (state_reg == ST_FILL) & (bus.flush | timeout_hit);

    // FSM state, lane count and keep mask registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            keep_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            keep_reg  <= keep_next;
        end
    end

    // Next state, lane count and keep mask from pop, handshake and close
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        keep_next  = keep_reg;
        case (state_reg)
            ST_IDLE, ST_FILL: begin
                if (pop) begin
                    cnt_next  = cnt_reg + CNT_W'(1);
                    keep_next = keep_reg | (PACK'(1) << cnt_reg);
                    if (((cnt_reg + CNT_W'(1)) == CNT_W'(PACK)) || close_req) begin
                        state_next = ST_HOLD;
                    end else begin
                        state_next = ST_FILL;
                    end
                end else if (close_req) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (handshake) begin
                    if (pop) begin
                        cnt_next   = CNT_W'(1);
                        keep_next  = PACK'(1);
                        state_next = ST_FILL;
                    end else begin
                        cnt_next   = '0;
                        keep_next  = '0;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                keep_next  = '0;
            end
        endcase
    end

    // One register per lane; lanes are zeroed when their beat is accepted
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
        // Load on a pop aimed at this lane, otherwise clear on handshake
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_reg[gi] <= '0;
            end else if (pop && (wr_idx == CNT_W'(gi))) begin
                lane_reg[gi] <= bus.fifo_data;
            end else if (handshake) begin
                lane_reg[gi] <= '0;
            end
        end
    end

    // Flatten the lane array into the output beat, lane 0 at the bottom
    always_comb begin
        m_data_comb = '0;
        for (int k = 0; k < PACK; k++) begin
            m_data_comb[k*BITS +: BITS] = lane_reg[k];
        end
    end

    assign bus.fifo_read = pop;
    assign bus.m_data    = m_data_comb;
    assign bus.m_keep    = keep_reg;
    assign bus.m_valid   = (state_reg == ST_HOLD);
    assign bus.busy      = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer. A queue-based model of the lane
// contents is checked against the DUT every cycle, and directed scenarios
// pin literal values. Honours PACKER_TIMEOUT_EN for the idle-timeout case.
module tb_fifo_word_packer;
    localparam int BITS      = 12;
    localparam int PACK      = 2;
    localparam int TIMEOUT   = 8;
    localparam int TIMEOUT_W = 4;
    localparam int DW        = BITS * PACK;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    fifo_word_packer_if #(.BITS(BITS), .PACK(PACK)) bus ();

    fifo_word_packer #(
        .BITS      (BITS),
        .PACK      (PACK),
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Environment FIFO contents and model state
    logic [BITS-1:0] fifo_q [$];
    logic [BITS-1:0] lanes  [$];
    bit              presented  = 1'b0;
    int              idle       = 0;
    bit              model_live = 1'b0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic src_refresh();
        bus.fifo_ready = (fifo_q.size() > 0);
        bus.fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        src_refresh();
    endtask

    task automatic push(input logic [BITS-1:0] w);
        fifo_q.push_back(w);
        src_refresh();
    endtask

    // Model update and FIFO pop at each rising edge
    always @(posedge clk) begin
        bit fill_before;
        bit m_pop;
        bit fire;
        logic [BITS-1:0] head;
        if (rst) begin
            lanes.delete();
            presented  = 1'b0;
            idle       = 0;
            model_live = 1'b1;
        end else begin
            fill_before = !presented && (lanes.size() > 0);
            m_pop       = (fifo_q.size() > 0) && (!presented || bus.m_ready);
            head        = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            fire        = 1'b0;
            if (presented && bus.m_ready) begin
                $display("[TB] beat accepted data=%06h keep=%b", bus.m_data, bus.m_keep);
                lanes.delete();
                presented = 1'b0;
            end
            if (m_pop) begin
                lanes.push_back(head);
                if (lanes.size() == PACK) presented = 1'b1;
            end
            if (fill_before && !m_pop) begin
                idle++;
`ifdef PACKER_TIMEOUT_EN
                if (idle == TIMEOUT) fire = 1'b1;
`endif
            end
            if (fill_before && (bus.flush || fire)) presented = 1'b1;
            if (m_pop || presented || (lanes.size() == 0)) idle = 0;
        end
        if (bus.fifo_read && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
    end

    // Compare DUT outputs with the model in mid-cycle
    always @(negedge clk) begin
        logic [DW-1:0]   exp_data;
        logic [PACK-1:0] exp_keep;
        logic            exp_read;
        if (model_live) begin
            exp_data = '0;
            exp_keep = '0;
            for (int k = 0; k < lanes.size(); k++) begin
                exp_data[k*BITS +: BITS] = lanes[k];
                exp_keep[k] = 1'b1;
            end
            exp_read = !rst && (fifo_q.size() > 0) && (!presented || bus.m_ready);
            check("cyc_fifo_read", 64'(bus.fifo_read), 64'(exp_read));
            check("cyc_m_valid",   64'(bus.m_valid),   64'(presented));
            check("cyc_m_keep",    64'(bus.m_keep),    64'(exp_keep));
            check("cyc_m_data",    64'(bus.m_data),    64'(exp_data));
            check("cyc_busy",      64'(bus.busy),      64'(lanes.size() > 0));
        end
    end

    initial begin
        int rise_at;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b1;
        src_refresh();

        // 1: reset held two cycles while the FIFO has data
        rst = 1'b1;
        push(12'h0F0);
        push(12'h0F1);
        tick();
        tick();
        check("rst_fifo_read", 64'(bus.fifo_read), 64'd0);
        check("rst_m_valid",   64'(bus.m_valid),   64'd0);
        check("rst_m_keep",    64'(bus.m_keep),    64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_m_data",    64'(bus.m_data),    64'd0);
        rst = 1'b0;
        tick();
        tick();
        check("first_beat", 64'(bus.m_data), 64'h0F10F0);
        tick();

        // 2: back-to-back words, consumer always ready
        push(12'h001);
        push(12'h002);
        push(12'h003);
        push(12'h004);
        tick();
        tick();
        check("t2_valid", 64'(bus.m_valid), 64'd1);
        check("t2_data",  64'(bus.m_data),  64'h002001);
        check("t2_keep",  64'(bus.m_keep),  64'h3);
        check("t2_overlap_pop", 64'(bus.fifo_read), 64'd1);
        tick();
        tick();
        check("t2_beat2", 64'(bus.m_data), 64'h004003);
        tick();

        // 3: back-pressure with five words queued
        bus.m_ready = 1'b0;
        push(12'h011);
        push(12'h012);
        push(12'h013);
        push(12'h014);
        push(12'h015);
        for (int i = 0; i < 5; i++) tick();
        check("t3_left",  64'(fifo_q.size()),   64'd3);
        check("t3_read",  64'(bus.fifo_read),   64'd0);
        check("t3_data",  64'(bus.m_data),      64'h012011);
        check("t3_valid", 64'(bus.m_valid),     64'd1);
        bus.m_ready = 1'b1;
        tick();
        tick();
        check("t3_beat2", 64'(bus.m_data), 64'h014013);
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t3_partial_data", 64'(bus.m_data), 64'h000015);
        check("t3_partial_keep", 64'(bus.m_keep), 64'h1);
        tick();

        // 4: single word then flush; flush in IDLE ignored
        push(12'hABC);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t4_data",  64'(bus.m_data),  64'h000ABC);
        check("t4_keep",  64'(bus.m_keep),  64'h1);
        check("t4_valid", 64'(bus.m_valid), 64'd1);
        tick();
        bus.flush = 1'b1;
        tick();
        tick();
        bus.flush = 1'b0;
        tick();
        check("t4_idle_flush_valid", 64'(bus.m_valid), 64'd0);
        check("t4_idle_flush_busy",  64'(bus.busy),    64'd0);

        // 5: lone word, then FIFO runs dry
        push(12'h5A5);
        tick();
        rise_at = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus.m_valid && (rise_at < 0)) begin
                rise_at = k;
                check("t5_keep", 64'(bus.m_keep), 64'h1);
                check("t5_data", 64'(bus.m_data), 64'h0005A5);
            end
        end
`ifdef PACKER_TIMEOUT_EN
        check("t5_timeout_cycles", 64'(rise_at), 64'd8);
`else
        check("t5_no_beat", 64'(rise_at), 64'hFFFF_FFFF_FFFF_FFFF);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
`endif

        // 6: reset during HOLD, flush in HOLD ignored, fresh beat after
        bus.m_ready = 1'b0;
        push(12'h021);
        push(12'h022);
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t6_hold_valid", 64'(bus.m_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", 64'(bus.m_valid), 64'd0);
        check("t6_rst_busy",  64'(bus.busy),    64'd0);
        check("t6_rst_keep",  64'(bus.m_keep),  64'd0);
        push(12'h031);
        push(12'h032);
        tick();
        tick();
        check("t6_fresh_data", 64'(bus.m_data), 64'h032031);
        check("t6_fresh_keep", 64'(bus.m_keep), 64'h3);
        bus.m_ready = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
